// File: rtl/rcu_pkg.sv
// Shared types for the per-VC route computation unit: port codes, flit type codes, route table entry.
package rcu_pkg;

    typedef enum logic [2:0] {
        P_NONE  = 3'd0,
        P_LOCAL = 3'd1,
        P_EAST  = 3'd2,
        P_WEST  = 3'd3,
        P_NORTH = 3'd4,
        P_SOUTH = 3'd5
    } port_e;

    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_TAIL   = 2'b01,
        FT_BODY   = 2'b10,
        FT_HEAD   = 2'b11
    } ft_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rte_t;

endpackage

// File: rtl/rcu_dor_calc.sv
// Dimension-order (X then Y) destination-to-port calculation; TORUS_WRAP_EN selects minimal-path torus.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the destination coordinates.
module rcu_dor_calc
    import rcu_pkg::*;
#(
    parameter int CW    = 4,
    parameter int MY_X  = 2,
    parameter int MY_Y  = 1,
    parameter int DIM_X = 4,
    parameter int DIM_Y = 4
) (
    input  logic [CW-1:0] dx,
    input  logic [CW-1:0] dy,
    output port_e         port,
    output logic          err_range
);

    localparam int W = CW + 2;
    localparam logic [W-1:0] DXW = W'(DIM_X);
    localparam logic [W-1:0] DYW = W'(DIM_Y);
    localparam logic [W-1:0] MXW = W'(MY_X);
    localparam logic [W-1:0] MYW = W'(MY_Y);

    logic [W-1:0] xe;
    logic [W-1:0] ye;
    logic         x_pos;
    logic         y_pos;

    assign xe = W'(dx);
    assign ye = W'(dy);
    assign err_range = (xe >= DXW) || (ye >= DYW);

`ifdef TORUS_WRAP_EN
    logic [W-1:0] dist_x;
    logic [W-1:0] dist_y;

    // Forward distance modulo DIM; going positive wins when it is no longer than going back (tie -> positive).
    always_comb begin
        dist_x = xe + DXW - MXW;
        if (dist_x >= DXW) dist_x = dist_x - DXW;
        dist_y = ye + DYW - MYW;
        if (dist_y >= DYW) dist_y = dist_y - DYW;
        x_pos = ({dist_x[W-2:0], 1'b0} <= DXW);
        y_pos = ({dist_y[W-2:0], 1'b0} <= DYW);
    end
`else
    assign x_pos = (xe > MXW);
    assign y_pos = (ye > MYW);
`endif

    always_comb begin
        port = P_NONE;
        if (err_range)                    port = P_NONE;
        else if (xe == MXW && ye == MYW)  port = P_LOCAL;
        else if (xe != MXW)               port = x_pos ? P_EAST : P_WEST;
        else                              port = y_pos ? P_SOUTH : P_NORTH;
    end

endmodule

// File: rtl/rcu_vc_route.sv
// Per-VC route computation for one input port (mesh, or torus with TORUS_WRAP_EN): head routes latched per VC.
// Latency: exactly one cycle, full throughput through a single registered stage.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold stable while stalled.
module rcu_vc_route
    import rcu_pkg::*;
#(
    parameter int FW     = 39,
    parameter int CW     = 4,
    parameter int MY_X   = 2,
    parameter int MY_Y   = 1,
    parameter int DIM_X  = 4,
    parameter int DIM_Y  = 4,
    parameter int NUM_VC = 4,
    localparam int VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk_t,
    input  logic              rst_t,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FW:0]       in_flit,
    input  logic [VCW-1:0]    in_vc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW:0]       out_flit,
    output logic [VCW-1:0]    out_vc,
    output logic [2:0]        out_port,
    output logic [NUM_VC-1:0] vc_busy,
    output logic              err
);

    logic  xfer_in;
    ft_e   ftype;
    port_e calc_port;
    logic  calc_err;
    rte_t  table_q [NUM_VC];
    rte_t  cur;
    port_e sel_port;
    logic  set_err;
    logic  wr_en;
    rte_t  wr_ent;
    port_e out_port_q;

    assign in_ready = !out_valid | out_ready;
    assign xfer_in  = in_valid & in_ready;
    assign ftype    = ft_e'(in_flit[FW:FW-1]);
    assign cur      = table_q[in_vc];
    assign out_port = out_port_q;

    rcu_dor_calc #(
        .CW    (CW),
        .MY_X  (MY_X),
        .MY_Y  (MY_Y),
        .DIM_X (DIM_X),
        .DIM_Y (DIM_Y)
    ) u_calc (
        .dx        (in_flit[FW-10 -: CW]),
        .dy        (in_flit[FW-10-CW -: CW]),
        .port      (calc_port),
        .err_range (calc_err)
    );

    // Body/tail on a VC with no latched route is still forwarded, but with NONE and a sticky error.
    always_comb begin
        sel_port = P_NONE;
        set_err  = 1'b0;
        wr_en    = 1'b0;
        wr_ent   = '{valid: 1'b0, port: P_NONE};
        case (ftype)
            FT_HEAD: begin
                sel_port = calc_port;
                set_err  = calc_err | cur.valid;
                wr_en    = 1'b1;
                wr_ent   = '{valid: 1'b1, port: calc_port};
            end
            FT_BODY: begin
                sel_port = cur.valid ? cur.port : P_NONE;
                set_err  = !cur.valid;
            end
            FT_TAIL: begin
                sel_port = cur.valid ? cur.port : P_NONE;
                set_err  = !cur.valid;
                wr_en    = 1'b1;
            end
            default: begin
                sel_port = calc_port;
                set_err  = calc_err | cur.valid;
            end
        endcase
    end

    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            for (int v = 0; v < NUM_VC; v++) table_q[v] <= '{valid: 1'b0, port: P_NONE};
        end else if (xfer_in && wr_en) begin
            table_q[in_vc] <= wr_ent;
        end
    end

    always_comb begin
        vc_busy = '0;
        for (int v = 0; v < NUM_VC; v++) vc_busy[v] = table_q[v].valid;
    end

    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            out_valid  <= 1'b0;
            out_flit   <= '0;
            out_vc     <= '0;
            out_port_q <= P_NONE;
            err        <= 1'b0;
        end else begin
            if (xfer_in) begin
                out_valid  <= 1'b1;
                out_flit   <= in_flit;
                out_vc     <= in_vc;
                out_port_q <= sel_port;
                if (set_err) err <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rcu_vc_route.sv
// Directed bench for rcu_vc_route: main instance at MY=(2,1), second instance at MY=(0,0) for wrap checks.
module tb_rcu_vc_route;

    logic        clk_t = 1'b0;
    logic        rst_t;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [39:0] in_flit;
    logic [1:0]  in_vc;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [39:0] out_flit, out_flit0;
    logic [1:0]  out_vc, out_vc0;
    logic [2:0]  out_port, out_port0;
    logic [3:0]  vc_busy, vc_busy0;
    logic        err, err0;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef TORUS_WRAP_EN
    localparam logic [2:0] EXP_WEST0 = 3'd2;
    localparam logic [2:0] EXP_D30   = 3'd3;
    localparam logic [2:0] EXP_D03   = 3'd4;
`else
    localparam logic [2:0] EXP_WEST0 = 3'd3;
    localparam logic [2:0] EXP_D30   = 3'd2;
    localparam logic [2:0] EXP_D03   = 3'd5;
`endif

    always #5 clk_t = ~clk_t;

    rcu_vc_route u_dut (
        .clk_t(clk_t), .rst_t(rst_t), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .in_vc(in_vc), .out_valid(out_valid), .out_ready(out_ready),
        .out_flit(out_flit), .out_vc(out_vc), .out_port(out_port), .vc_busy(vc_busy), .err(err)
    );

    rcu_vc_route #(.MY_X(0), .MY_Y(0)) u_dut0 (
        .clk_t(clk_t), .rst_t(rst_t), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_flit(in_flit), .in_vc(in_vc), .out_valid(out_valid0), .out_ready(out_ready),
        .out_flit(out_flit0), .out_vc(out_vc0), .out_port(out_port0), .vc_busy(vc_busy0), .err(err0)
    );

    function automatic logic [39:0] mk(input logic [1:0] ft, input logic [3:0] x,
                                       input logic [3:0] y, input logic [7:0] tag);
        logic [39:0] f;
        f = 40'h0;
        f[39:38] = ft;
        f[37:30] = ~tag;
        f[29:26] = x;
        f[25:22] = y;
        f[7:0]   = tag;
        return f;
    endfunction

    task automatic step();
        @(posedge clk_t);
        #1;
    endtask

    task automatic put(input logic [1:0] ft, input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] vc, input logic [7:0] tag, output logic [39:0] sent);
        in_valid = 1'b1;
        in_flit  = mk(ft, x, y, tag);
        in_vc    = vc;
        sent     = in_flit;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_t = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
        in_flit = 40'h0; in_vc = 2'd0;
        repeat (2) step();
        n_chk++; if ({out_valid, out_flit, out_vc, out_port} !== 46'h0)
            $display("FAIL reset_out: got valid=%b flit=%h vc=%0d port=%0d, want all 0", out_valid, out_flit, out_vc, out_port);
            else n_pass++;
        n_chk++; if ({vc_busy, err} !== 5'h0) $display("FAIL reset_busy_err: got busy=%b err=%b, want 0", vc_busy, err); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        rst_t = 1'b1;
        step();
    endtask

    task automatic test_local();
        logic [39:0] s;
        put(2'b11, 4'd2, 4'd1, 2'd1, 8'h10, s);
        n_chk++; if ({out_valid, out_port, out_vc, out_flit} !== {1'b1, 3'd1, 2'd1, s})
            $display("FAIL local_head: got v=%b port=%0d vc=%0d flit=%h want 1/1/1/%h", out_valid, out_port, out_vc, out_flit, s); else n_pass++;
        n_chk++; if (vc_busy !== 4'b0010) $display("FAIL local_busy_set: got %b want 0010", vc_busy); else n_pass++;
        put(2'b01, 4'd0, 4'd0, 2'd1, 8'h11, s);
        n_chk++; if ({out_port, out_flit} !== {3'd1, s})
            $display("FAIL local_tail: got port=%0d flit=%h want 1 %h", out_port, out_flit, s); else n_pass++;
        n_chk++; if (vc_busy !== 4'b0000) $display("FAIL local_busy_clr: got %b want 0000", vc_busy); else n_pass++;
        step();
        n_chk++; if ({out_valid, err} !== 2'b00) $display("FAIL local_idle: got valid=%b err=%b want 0 0", out_valid, err); else n_pass++;
    endtask

    task automatic test_west();
        logic [39:0] s;
        logic [1:0]  fts [4] = '{2'b11, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            put(fts[i], (i == 0) ? 4'd0 : 4'd3, (i == 0) ? 4'd1 : 4'd3, 2'd0, 8'h20 + 8'(i), s);
            n_chk++; if ({out_valid, out_port, out_flit} !== {1'b1, EXP_WEST0, s})
                $display("FAIL west_flit%0d: got v=%b port=%0d flit=%h want 1 %0d %h", i, out_valid, out_port, out_flit, EXP_WEST0, s); else n_pass++;
        end
        n_chk++; if (vc_busy !== 4'b0000) $display("FAIL west_busy_clr: got %b want 0000", vc_busy); else n_pass++;
    endtask

    task automatic test_interleave();
        logic [39:0] s;
        logic [1:0]  fts [6] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 6; i++) begin
            put(fts[i], (i % 2 == 0) ? 4'd2 : 4'd3, (i % 2 == 0) ? 4'd3 : 4'd1,
                (i % 2 == 0) ? 2'd2 : 2'd3, 8'h30 + 8'(i), s);
            n_chk++; if ({out_port, out_vc, out_flit} !== {((i % 2 == 0) ? 3'd5 : 3'd2), ((i % 2 == 0) ? 2'd2 : 2'd3), s})
                $display("FAIL ilv_flit%0d: got port=%0d vc=%0d flit=%h", i, out_port, out_vc, out_flit); else n_pass++;
            if (i == 1) begin
                n_chk++; if (vc_busy !== 4'b1100) $display("FAIL ilv_busy: got %b want 1100", vc_busy); else n_pass++;
            end
        end
        n_chk++; if ({vc_busy, err} !== 5'h0) $display("FAIL ilv_end: got busy=%b err=%b want 0 0", vc_busy, err); else n_pass++;
    endtask

    task automatic test_stall();
        logic [39:0] h, b, t;
        put(2'b11, 4'd3, 4'd1, 2'd1, 8'h40, h);
        n_chk++; if (out_port !== 3'd2) $display("FAIL stall_head_port: got %0d want 2", out_port); else n_pass++;
        out_ready = 1'b0;
        in_valid = 1'b1; in_flit = mk(2'b10, 4'd0, 4'd0, 8'h41); in_vc = 2'd1; b = in_flit;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if ({in_ready, out_valid, out_flit, out_port} !== {1'b0, 1'b1, h, 3'd2})
                $display("FAIL stall_hold%0d: got rdy=%b v=%b flit=%h port=%0d want 0 1 %h 2", i, in_ready, out_valid, out_flit, out_port, h); else n_pass++;
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_chk++; if ({out_valid, out_flit, out_port} !== {1'b1, b, 3'd2})
            $display("FAIL stall_body: got v=%b flit=%h port=%0d want 1 %h 2", out_valid, out_flit, out_port, b); else n_pass++;
        put(2'b01, 4'd0, 4'd0, 2'd1, 8'h42, t);
        n_chk++; if ({out_flit, out_port} !== {t, 3'd2}) $display("FAIL stall_tail: got flit=%h port=%0d want %h 2", out_flit, out_port, t); else n_pass++;
        step();
        n_chk++; if ({out_valid, vc_busy} !== 5'h0) $display("FAIL stall_drain: got v=%b busy=%b want 0 0", out_valid, vc_busy); else n_pass++;
    endtask

    task automatic test_err_and_reset();
        logic [39:0] s;
        put(2'b10, 4'd1, 4'd1, 2'd0, 8'h50, s);
        n_chk++; if ({out_valid, out_port, err} !== {1'b1, 3'd0, 1'b1})
            $display("FAIL idle_body: got v=%b port=%0d err=%b want 1 0 1", out_valid, out_port, err); else n_pass++;
        put(2'b11, 4'd2, 4'd2, 2'd2, 8'h51, s);
        step();
        n_chk++; if ({err, vc_busy} !== 5'b1_0100) $display("FAIL err_sticky: got err=%b busy=%b want 1 0100", err, vc_busy); else n_pass++;
        rst_t = 1'b0;
        #1;
        n_chk++; if ({err, vc_busy, out_valid} !== 6'h0) $display("FAIL mid_reset: got err=%b busy=%b v=%b want 0", err, vc_busy, out_valid); else n_pass++;
        step();
        rst_t = 1'b1;
        step();
        put(2'b00, 4'd5, 4'd0, 2'd0, 8'h52, s);
        n_chk++; if ({out_valid, out_port, err, vc_busy} !== {1'b1, 3'd0, 1'b1, 4'b0})
            $display("FAIL range: got v=%b port=%0d err=%b busy=%b want 1 0 1 0000", out_valid, out_port, err, vc_busy); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0]  xs  [3] = '{4'd3, 4'd2, 4'd0};
        logic [3:0]  ys  [3] = '{4'd0, 4'd0, 4'd3};
        logic [2:0]  exp [3];
        exp[0] = EXP_D30; exp[1] = 3'd2; exp[2] = EXP_D03;
        for (int i = 0; i < 3; i++) begin
            in_valid0 = 1'b1; in_flit = mk(2'b00, xs[i], ys[i], 8'h60 + 8'(i)); in_vc = 2'd0;
            step();
            in_valid0 = 1'b0;
            n_chk++; if ({out_valid0, out_port0, err0} !== {1'b1, exp[i], 1'b0})
                $display("FAIL wrap%0d: got v=%b port=%0d err=%b want 1 %0d 0", i, out_valid0, out_port0, err0, exp[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_local();
        test_west();
        test_interleave();
        test_stall();
        test_wrap();
        test_err_and_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
